// File: rtl/red_pitaya_normalizer_ctrl_pkg.sv
// Shared types and widths for the normalizer sequencer.
package red_pitaya_normalizer_ctrl_pkg;

  localparam int unsigned StateBits = 3;
  localparam int unsigned RetryBits = 4;

  // State codes are visible on state_o, so their values are fixed.
  typedef enum logic [StateBits-1:0] {
    StIdle    = 3'd0,
    StPreset  = 3'd1,
    StSettle  = 3'd2,
    StAcquire = 3'd3,
    StLocked  = 3'd4,
    StRetry   = 3'd5,
    StFault   = 3'd6
  } state_e;

endpackage

// File: rtl/red_pitaya_normalizer_gain_ramp.sv
// Prescaled, saturating step-toward-target gain register.
module red_pitaya_normalizer_gain_ramp #(
  parameter int unsigned GAINBITS  = 16,
  parameter int unsigned RAMPSHIFT = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       enable_i,
  input  logic signed [GAINBITS-1:0] target_i,
  input  logic        [GAINBITS-2:0] step_i,
  output logic signed [GAINBITS-1:0] gain_o
);

  logic        [RAMPSHIFT-1:0] presc_q, presc_d;
  logic signed [GAINBITS-1:0]  gain_q, gain_d;
  logic signed [GAINBITS:0]    gain_ext, target_ext, step_ext, up_sum, dn_sum;
  logic                        tick;

  // Next prescaler count and gain; sums are one bit wider so they never wrap.
  always_comb begin
    gain_ext   = {gain_q[GAINBITS-1], gain_q};
    target_ext = {target_i[GAINBITS-1], target_i};
    step_ext   = {2'b00, step_i};
    up_sum     = gain_ext + step_ext;
    dn_sum     = gain_ext - step_ext;
    tick       = (presc_q == '1);
    presc_d    = presc_q;
    gain_d     = gain_q;
    if (clear_i) begin
      presc_d = '0;
      gain_d  = '0;
    end else if (enable_i) begin
      presc_d = presc_q + RAMPSHIFT'(1);
      if (tick) begin
        if (gain_ext < target_ext) begin
          gain_d = (up_sum > target_ext) ? target_i : up_sum[GAINBITS-1:0];
        end else if (gain_ext > target_ext) begin
          gain_d = (dn_sum < target_ext) ? target_i : dn_sum[GAINBITS-1:0];
        end
      end
    end
  end

  // Prescaler and gain registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
      gain_q  <= '0;
    end else begin
      presc_q <= presc_d;
      gain_q  <= gain_d;
    end
  end

  assign gain_o = gain_q;

endmodule

// File: rtl/red_pitaya_normalizer_ctrl.sv
// Sequencer for one normalizer: preset, settle, gain ramp, lock watch, retry and fault.
module red_pitaya_normalizer_ctrl
  import red_pitaya_normalizer_ctrl_pkg::*;
#(
  parameter int unsigned SIGNALBITS = 14,
  parameter int unsigned GAINBITS   = 16,
  parameter int unsigned CNTBITS    = 24,
  parameter int unsigned RAMPSHIFT  = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic signed [GAINBITS-1:0]   gain_target_i,
  input  logic        [GAINBITS-2:0]   gain_step_i,
  input  logic signed [15:0]           ival_i,
  input  logic        [CNTBITS-1:0]    settle_cycles_i,
  input  logic        [SIGNALBITS-2:0] lock_thresh_i,
  input  logic        [CNTBITS-1:0]    lock_count_i,
  input  logic        [CNTBITS-1:0]    unlock_count_i,
  input  logic        [RetryBits-1:0]  max_retries_i,
  input  logic signed [SIGNALBITS-1:0] error_i,
  output logic                         filter_on_o,
  output logic signed [GAINBITS-1:0]   gain_o,
  output logic                         ival_write_o,
  output logic signed [15:0]           set_ival_o,
  output logic        [StateBits-1:0]  state_o,
  output logic                         locked_o,
  output logic                         fault_o,
  output logic        [RetryBits-1:0]  retries_o
);

  state_e                 state_q, state_d;
  logic [CNTBITS-1:0]     settle_cnt_q, settle_cnt_d;
  logic [CNTBITS-1:0]     lock_cnt_q, lock_cnt_d;
  logic [CNTBITS-1:0]     unlock_cnt_q, unlock_cnt_d;
  logic [RetryBits-1:0]   retries_q, retries_d;
  logic                   filter_on_q, filter_on_d;
  logic                   ival_write_q, ival_write_d;
  logic signed [15:0]     set_ival_q, set_ival_d;
  logic                   locked_q, locked_d;
  logic                   fault_q, fault_d;

  logic [SIGNALBITS-2:0]  err_mag;
  logic                   err_in;
  logic [CNTBITS:0]       settle_inc, lock_inc, unlock_inc;
  logic                   settle_done, lock_hit, unlock_hit;
  logic                   ramp_active, ramp_clear;

  // One's-complement magnitude keeps the most negative code inside SIGNALBITS-1 bits.
  always_comb begin
    err_mag     = error_i[SIGNALBITS-1] ? ~error_i[SIGNALBITS-2:0] : error_i[SIGNALBITS-2:0];
    err_in      = (err_mag <= lock_thresh_i);
    settle_inc  = {1'b0, settle_cnt_q} + (CNTBITS+1)'(1);
    lock_inc    = {1'b0, lock_cnt_q} + (CNTBITS+1)'(1);
    unlock_inc  = {1'b0, unlock_cnt_q} + (CNTBITS+1)'(1);
    settle_done = (settle_inc >= {1'b0, settle_cycles_i});
    lock_hit    = (lock_count_i == '0) || (err_in && (lock_inc >= {1'b0, lock_count_i}));
    unlock_hit  = (unlock_count_i == '0) || (!err_in && (unlock_inc >= {1'b0, unlock_count_i}));
  end

  // Next-state and counter logic; enable_i low overrides every transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    unlock_cnt_d = unlock_cnt_q;
    retries_d    = retries_q;
    case (state_q)
      StIdle: if (enable_i) state_d = StPreset;
      StPreset: begin
        state_d      = StSettle;
        settle_cnt_d = '0;
      end
      StSettle: begin
        if (settle_done) begin
          state_d    = StAcquire;
          lock_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_inc[CNTBITS-1:0];
        end
      end
      StAcquire: begin
        if (lock_hit) begin
          state_d      = StLocked;
          lock_cnt_d   = '0;
          unlock_cnt_d = '0;
        end else begin
          lock_cnt_d = err_in ? lock_inc[CNTBITS-1:0] : '0;
        end
      end
      StLocked: begin
        if (unlock_hit) begin
          unlock_cnt_d = '0;
          if (retries_q < max_retries_i) begin
            state_d   = StRetry;
            retries_d = retries_q + RetryBits'(1);
          end else begin
            state_d = StFault;
          end
        end else begin
          unlock_cnt_d = err_in ? '0 : unlock_inc[CNTBITS-1:0];
        end
      end
      StRetry: state_d = StPreset;
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
    if (!enable_i) state_d = StIdle;
    if (state_d == StIdle) begin
      settle_cnt_d = '0;
      lock_cnt_d   = '0;
      unlock_cnt_d = '0;
      retries_d    = '0;
    end
  end

  // Outputs are decoded from the next state so they change on the transition edge.
  always_comb begin
    filter_on_d  = (state_d == StAcquire) || (state_d == StLocked);
    ival_write_d = (state_d == StPreset);
    set_ival_d   = (state_d == StPreset) ? ival_i : '0;
    locked_d     = (state_d == StLocked);
    fault_d      = (state_d == StFault);
    ramp_active  = filter_on_d;
    // Restart the prescaler on ACQUIRE entry so the first tick is a full period away.
    ramp_clear   = !ramp_active || ((state_d == StAcquire) && (state_q != StAcquire));
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      lock_cnt_q   <= '0;
      unlock_cnt_q <= '0;
      retries_q    <= '0;
      filter_on_q  <= 1'b0;
      ival_write_q <= 1'b0;
      set_ival_q   <= '0;
      locked_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      unlock_cnt_q <= unlock_cnt_d;
      retries_q    <= retries_d;
      filter_on_q  <= filter_on_d;
      ival_write_q <= ival_write_d;
      set_ival_q   <= set_ival_d;
      locked_q     <= locked_d;
      fault_q      <= fault_d;
    end
  end

  red_pitaya_normalizer_gain_ramp #(
    .GAINBITS  (GAINBITS),
    .RAMPSHIFT (RAMPSHIFT)
  ) u_gain_ramp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (ramp_clear),
    .enable_i (ramp_active),
    .target_i (gain_target_i),
    .step_i   (gain_step_i),
    .gain_o   (gain_o)
  );

  assign filter_on_o  = filter_on_q;
  assign ival_write_o = ival_write_q;
  assign set_ival_o   = set_ival_q;
  assign state_o      = state_q;
  assign locked_o     = locked_q;
  assign fault_o      = fault_q;
  assign retries_o    = retries_q;

endmodule

// File: tb/tb_red_pitaya_normalizer_ctrl.sv
// Directed bench for the normalizer sequencer, RAMPSHIFT=4 (16-cycle ramp ticks).
module tb_red_pitaya_normalizer_ctrl;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic signed [15:0] target;
  logic        [14:0] step;
  logic signed [15:0] ival;
  logic        [23:0] settle, lock_c, unlock_c;
  logic        [12:0] thresh;
  logic        [3:0]  max_r;
  logic signed [13:0] err;

  logic               filter_on;
  logic signed [15:0] gain;
  logic               ival_write;
  logic signed [15:0] set_ival;
  logic        [2:0]  state;
  logic               locked;
  logic               fault;
  logic        [3:0]  retries;

  int cyc = 0;
  int base = 0;
  int errors = 0;
  int checks = 0;

  red_pitaya_normalizer_ctrl #(
    .SIGNALBITS (14),
    .GAINBITS   (16),
    .CNTBITS    (24),
    .RAMPSHIFT  (4)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .gain_target_i   (target),
    .gain_step_i     (step),
    .ival_i          (ival),
    .settle_cycles_i (settle),
    .lock_thresh_i   (thresh),
    .lock_count_i    (lock_c),
    .unlock_count_i  (unlock_c),
    .max_retries_i   (max_r),
    .error_i         (err),
    .filter_on_o     (filter_on),
    .gain_o          (gain),
    .ival_write_o    (ival_write),
    .set_ival_o      (set_ival),
    .state_o         (state),
    .locked_o        (locked),
    .fault_o         (fault),
    .retries_o       (retries)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (rel cycle %0d)", tag, obs, expv, cyc - base);
    end
  endtask

  // Advance to 1 time unit after the n-th edge counted from base.
  task automatic to_edge(input int n);
    while ((cyc - base) < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; target = '0; step = '0; ival = '0; settle = '0;
    lock_c = '0; unlock_c = '0; thresh = '0; max_r = '0; err = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_filter", filter_on, 0);
    chk("rst_gain", $signed(gain), 0);
    chk("rst_ival_write", ival_write, 0);
    chk("rst_set_ival", set_ival, 0);
    chk("rst_locked", locked, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retries", retries, 0);
    rst = 1'b0;

    // Basic lock plus ramp up and down.
    ival = 16'sh1234; settle = 100; lock_c = 50; thresh = 200; err = 10;
    target = 1000; step = 300; unlock_c = 20; max_r = 2;
    base = cyc; enable = 1'b1;
    to_edge(1);   chk("preset_state", state, 1);
    chk("preset_strobe", ival_write, 1);
    chk("preset_value", set_ival, 32'h1234);
    to_edge(2);   chk("strobe_one_cycle", ival_write, 0);
    chk("settle_state", state, 2);
    to_edge(101); chk("filter_before", filter_on, 0);
    to_edge(102); chk("filter_rise", filter_on, 1);
    chk("acquire_state", state, 3);
    to_edge(117); chk("gain_pre_tick", $signed(gain), 0);
    to_edge(118); chk("gain_t1", $signed(gain), 300);
    to_edge(134); chk("gain_t2", $signed(gain), 600);
    to_edge(150); chk("gain_t3", $signed(gain), 900);
    to_edge(151); chk("locked_before", locked, 0);
    to_edge(152); chk("locked_rise", locked, 1);
    chk("locked_state", state, 4);
    to_edge(166); chk("gain_sat_up", $signed(gain), 1000);
    to_edge(182); chk("gain_hold", $signed(gain), 1000);
    target = -200;
    to_edge(198); chk("gain_dn1", $signed(gain), 700);
    to_edge(214); chk("gain_dn2", $signed(gain), 400);
    to_edge(230); chk("gain_dn3", $signed(gain), 100);
    to_edge(246); chk("gain_sat_dn", $signed(gain), -200);
    to_edge(262); chk("gain_hold_dn", $signed(gain), -200);
    chk("still_locked", state, 4);

    // Unlock, retry twice, then fault.
    err = -8192; settle = 3; lock_c = 4;
    to_edge(281); chk("pre_unlock1", state, 4);
    to_edge(282); chk("retry1_state", state, 5);
    chk("retry1_count", retries, 1);
    chk("retry1_gain", $signed(gain), 0);
    chk("retry1_filter", filter_on, 0);
    err = 10;
    to_edge(283); chk("retry1_preset", state, 1);
    chk("retry1_strobe", ival_write, 1);
    to_edge(287); chk("reacq_state", state, 3);
    to_edge(291); chk("relock_state", state, 4);
    err = -8192;
    to_edge(302); chk("reramp_pre", $signed(gain), 0);
    to_edge(303); chk("reramp_one_step", $signed(gain), -200);
    to_edge(310); chk("pre_unlock2", state, 4);
    to_edge(311); chk("retry2_state", state, 5);
    chk("retry2_count", retries, 2);
    err = 10;
    to_edge(320); chk("relock2_state", state, 4);
    err = -8192;
    to_edge(339); chk("pre_unlock3", state, 4);
    to_edge(340); chk("fault_state", state, 6);
    chk("fault_flag", fault, 1);
    chk("fault_retries", retries, 2);
    chk("fault_gain", $signed(gain), 0);
    chk("fault_filter", filter_on, 0);
    chk("fault_locked", locked, 0);
    to_edge(350); chk("fault_sticky", state, 6);
    enable = 1'b0;
    to_edge(351); chk("fault_exit", state, 0);
    chk("fault_exit_flag", fault, 0);
    chk("fault_exit_retries", retries, 0);

    // Chatter: in-runs of 5 never reach lock_count=10.
    err = 500; settle = 3; lock_c = 10;
    base = cyc; enable = 1'b1;
    to_edge(5); chk("chatter_acq", state, 3);
    for (int i = 0; i < 60; i++) begin
      err = (((i / 5) % 2) == 0) ? -14'sd201 : 14'sd201;
      @(posedge clk);
      #1;
      chk("chatter_hold", state, 3);
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("chatter_exit", state, 0);

    // Abort during SETTLE.
    settle = 100;
    base = cyc; enable = 1'b1;
    to_edge(10); chk("abort_settle_pre", state, 2);
    enable = 1'b0;
    to_edge(11); chk("abort_settle_state", state, 0);
    chk("abort_settle_filter", filter_on, 0);
    chk("abort_settle_gain", $signed(gain), 0);

    // Abort on the cycle the unlock count expires; -201 sits exactly on the threshold.
    settle = 3; lock_c = 4; unlock_c = 5; max_r = 2; err = -201;
    base = cyc; enable = 1'b1;
    to_edge(5);  chk("ab2_acq", state, 3);
    to_edge(9);  chk("ab2_lock_boundary", state, 4);
    err = 201;
    to_edge(14); chk("ab2_retry", state, 5);
    chk("ab2_retry_count", retries, 1);
    err = -201;
    to_edge(23); chk("ab2_relock", state, 4);
    err = 201;
    to_edge(27); chk("ab2_pre", state, 4);
    chk("ab2_pre_retries", retries, 1);
    enable = 1'b0;
    to_edge(28); chk("ab2_idle", state, 0);
    chk("ab2_retries", retries, 0);
    chk("ab2_gain", $signed(gain), 0);
    chk("ab2_filter", filter_on, 0);

    // Reset pulse mid-ACQUIRE with enable held high.
    lock_c = 100; err = 10; settle = 3;
    base = cyc; enable = 1'b1;
    to_edge(5); chk("rst_mid_acq", state, 3);
    to_edge(8);
    rst = 1'b1;
    to_edge(9); chk("rstm_state", state, 0);
    chk("rstm_filter", filter_on, 0);
    chk("rstm_gain", $signed(gain), 0);
    chk("rstm_ival_write", ival_write, 0);
    chk("rstm_locked", locked, 0);
    chk("rstm_fault", fault, 0);
    chk("rstm_retries", retries, 0);
    rst = 1'b0;
    to_edge(10); chk("rstm_preset", state, 1);
    chk("rstm_strobe", ival_write, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
